// File: rtl/texture_loader_pkg.sv
// Shared texture-memory definitions: address width, texel address field layout and loader FSM encoding.
// Also used by the texture memory, so field offsets live here rather than in the loader.
package texture_loader_pkg;

  localparam int TEX_ADDR_BITS = 13;

  // Texel address layout {row[5:0], side, col[5:0]}
  localparam int TEX_COL_LSB  = 0;
  localparam int TEX_COL_MSB  = 5;
  localparam int TEX_SIDE_BIT = 6;
  localparam int TEX_ROW_LSB  = 7;
  localparam int TEX_ROW_MSB  = 12;

  typedef struct packed {
    logic [5:0] row;
    logic       side;
    logic [5:0] col;
  } tex_addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_HI = 2'd1,
    ADDR_LO = 2'd2,
    DATA    = 2'd3
  } loader_state_e;

endpackage

// File: rtl/texture_loader_spi_byte_rx.sv
// SPI mode-0 byte receiver: 2-flop synchronisers, sclk rising-edge detect, MSB-first shifter.
// byte_valid pulses 1 clk after the 8th detected edge; no backpressure (needs f_clk >= 4*f_sclk).
module spi_byte_rx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       csb_async,
  input  logic       sclk_async,
  input  logic       mosi_async,
  output logic       csb_sync,
  output logic [7:0] rx_byte,
  output logic       byte_valid
);

  logic [1:0] csb_ff;
  logic [1:0] sclk_ff;
  logic [1:0] mosi_ff;
  logic       sclk_prev;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       sclk_rise;

  assign csb_sync  = csb_ff[1];
  assign sclk_rise = sclk_ff[1] & ~sclk_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csb_ff     <= 2'b11;
      sclk_ff    <= 2'b00;
      mosi_ff    <= 2'b00;
      sclk_prev  <= 1'b0;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      rx_byte    <= 8'd0;
      byte_valid <= 1'b0;
    end else begin
      csb_ff     <= {csb_ff[0], csb_async};
      sclk_ff    <= {sclk_ff[0], sclk_async};
      mosi_ff    <= {mosi_ff[0], mosi_async};
      sclk_prev  <= sclk_ff[1];
      byte_valid <= 1'b0;
      // Deselect drops any partial byte and masks sclk activity
      if (csb_ff[1]) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shreg   <= {shreg[5:0], mosi_ff[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte    <= {shreg, mosi_ff[1]};
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/texture_loader.sv
// SPI texture loader: 2-byte start address then one texel per byte, written at auto-incrementing addresses.
// wr_en follows the data byte's byte_valid by 1 clk; no backpressure, the memory must accept every strobe.
module texture_loader
  import texture_loader_pkg::*;
#(
  parameter int CHANNEL_BITS = 2,
  parameter int ADDR_BITS    = TEX_ADDR_BITS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      tex_csb,
  input  logic                      tex_sclk,
  input  logic                      tex_mosi,
  output logic                      wr_en,
  output logic [ADDR_BITS-1:0]      wr_addr,
  output logic [CHANNEL_BITS*3-1:0] wr_data,
  output logic                      busy,
  output logic [13:0]               load_count
);

  localparam int          DATA_BITS = CHANNEL_BITS * 3;
  localparam logic [13:0] COUNT_MAX = 14'h3FFF;

  loader_state_e state;
  loader_state_e state_nxt;

  logic       csb_s;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic [1:0] settle;
  logic       armed;
  logic       start;
  logic       take;

  spi_byte_rx u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .csb_async  (tex_csb),
    .sclk_async (tex_sclk),
    .mosi_async (tex_mosi),
    .csb_sync   (csb_s),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid)
  );

  // After reset the synchroniser holds a fake "high"; only arm once a real high is seen,
  // so a CSB that was already low across reset is not taken as a start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && csb_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (armed && !csb_s) state_nxt = ADDR_HI;
      ADDR_HI: if (byte_valid)      state_nxt = ADDR_LO;
      ADDR_LO: if (byte_valid)      state_nxt = DATA;
      DATA:    state_nxt = DATA;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && csb_s) state_nxt = IDLE;
  end

  assign start = (state == IDLE) && armed && !csb_s;
  // Deselect wins over a byte completing in the same cycle
  assign take  = byte_valid && !csb_s;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      load_count <= 14'd0;
    end else begin
      wr_en <= 1'b0;
      if (wr_en) wr_addr <= wr_addr + ADDR_BITS'(1);
      if (start) begin
        load_count <= 14'd0;
      end else if (wr_en && load_count != COUNT_MAX) begin
        load_count <= load_count + 14'd1;
      end
      if (take) begin
        case (state)
          ADDR_HI: wr_addr[ADDR_BITS-1:8] <= rx_byte[ADDR_BITS-9:0];
          ADDR_LO: wr_addr[7:0]           <= rx_byte;
          DATA: begin
            wr_en   <= 1'b1;
            wr_data <= rx_byte[DATA_BITS-1:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_texture_loader.sv
// Scoreboard bench for texture_loader: drives SPI transactions and checks each write against queued expectations.
module tb_texture_loader;

  localparam int AB = 13;
  localparam int DB = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tex_csb = 1'b1;
  logic          tex_sclk = 1'b0;
  logic          tex_mosi = 1'b0;
  logic          wr_en;
  logic [AB-1:0] wr_addr;
  logic [DB-1:0] wr_data;
  logic          busy;
  logic [13:0]   load_count;

  int n_checks = 0;
  int n_errors = 0;
  int half_ns  = 30;

  logic [AB+DB-1:0] exp_q[$];
  logic [AB-1:0]    exp_addr;
  logic [DB-1:0]    exp_img[8192];
  logic [DB-1:0]    got_img[8192];

  texture_loader #(.CHANNEL_BITS(2), .ADDR_BITS(AB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tex_csb    (tex_csb),
    .tex_sclk   (tex_sclk),
    .tex_mosi   (tex_mosi),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_without_expect", 32'(wr_en), 32'd0);
      end else begin
        check("wr", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
      end
      got_img[wr_addr] = wr_data;
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      tex_mosi = b[i];
      #(half_ns) tex_sclk = 1'b1;
      #(half_ns) tex_sclk = 1'b0;
    end
  endtask

  task automatic csb_low();
    @(negedge clk);
    tex_csb = 1'b0;
    #40;
  endtask

  task automatic csb_high();
    #40 tex_csb = 1'b1;
    #60;
  endtask

  task automatic send_addr(input logic [7:0] hi, input logic [7:0] lo);
    spi_bits(hi, 8);
    spi_bits(lo, 8);
    exp_addr = {hi[4:0], lo};
  endtask

  task automatic send_data(input logic [7:0] b);
    exp_q.push_back({exp_addr, b[5:0]});
    exp_img[exp_addr] = b[5:0];
    exp_addr = exp_addr + 13'd1;
    spi_bits(b, 8);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_data"}, 32'(wr_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_load_count"}, 32'(load_count), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic two-texel load from address 0
    csb_low();
    check("t1_busy", 32'(busy), 1);
    send_addr(8'h00, 8'h00);
    send_data(8'h2A);
    send_data(8'h15);
    csb_high();
    drain();
    check("t1_load_count", 32'(load_count), 2);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_next_addr", 32'(wr_addr), 2);

    // sclk activity while deselected must be ignored
    spi_bits(8'hFF, 8);
    #100;
    check("ign_busy", 32'(busy), 0);
    check("ign_wr_addr", 32'(wr_addr), 2);

    // Address wrap 8191 -> 0
    csb_low();
    send_addr(8'h1F, 8'hFF);
    send_data(8'h01);
    send_data(8'h02);
    csb_high();
    drain();
    check("t2_load_count", 32'(load_count), 2);
    check("t2_next_addr", 32'(wr_addr), 1);

    // Upper address bits ignored, data masked to texel width
    csb_low();
    send_addr(8'hE0, 8'h05);
    send_data(8'hC7);
    csb_high();
    drain();
    check("t3_load_count", 32'(load_count), 1);
    check("t3_next_addr", 32'(wr_addr), 6);

    // Partial data byte then deselect: no write
    csb_low();
    send_addr(8'h00, 8'h40);
    spi_bits(8'hAB, 4);
    csb_high();
    #200;
    check("t4_busy", 32'(busy), 0);
    check("t4_load_count", 32'(load_count), 0);
    check("t4_wr_addr", 32'(wr_addr), 32'h40);

    // Reset in the middle of a data byte
    csb_low();
    send_addr(8'h00, 8'h40);
    send_data(8'h3C);
    drain();
    check("t5_pre_load_count", 32'(load_count), 1);
    spi_bits(8'hFF, 5);
    #3 reset_n = 1'b0;
    #1 check_idle_zero("t5_async");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    spi_bits(8'h11, 8);
    spi_bits(8'h22, 8);
    #200;
    check("t5_busy", 32'(busy), 0);
    check("t5_load_count", 32'(load_count), 0);
    check("t5_wr_addr", 32'(wr_addr), 0);
    csb_high();

    // Long run at f_clk/4: full-image random load plus load_count saturation
    half_ns = 20;
    csb_low();
    send_addr(8'h00, 8'h00);
    for (int i = 0; i < 16390; i++) begin
      send_data(8'($urandom));
      if (i == 16382) begin
        drain();
        check("sat_reach", 32'(load_count), 32'd16383);
      end
    end
    drain();
    check("sat_hold", 32'(load_count), 32'd16383);
    check("sat_next_addr", 32'(wr_addr), 6);
    csb_high();
    check("sat_after_idle", 32'(load_count), 32'd16383);
    for (int a = 0; a < 8192; a++) check("img", 32'(got_img[a]), 32'(exp_img[a]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/texture_loader.md
TEXTURE_LOADER -- requirements
Module: texture_loader

Interface
REQ-001 SHALL have parameter CHANNEL_BITS, default 2: bits per colour channel; texel width is CHANNEL_BITS*3.
REQ-002 SHALL have parameter ADDR_BITS, default 13: texture memory address width (8192 texels).
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic is in this domain.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port tex_csb, input, 1: SPI chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port tex_sclk, input, 1: SPI clock, mode 0, asynchronous to clk.
REQ-007 SHALL have port tex_mosi, input, 1: SPI data, MSB first.
REQ-008 SHALL have port wr_en, output, 1: one-clk write strobe to the texture memory.
REQ-009 SHALL have port wr_addr, output, ADDR_BITS: texel address, layout {row[5:0], side, col[5:0]}.
REQ-010 SHALL have port wr_data, output, CHANNEL_BITS*3: texel value, XRGB packed, low bits of the received byte.
REQ-011 SHALL have port busy, output, 1: high while a transaction is open (synchronised CSB low).
REQ-012 SHALL have port load_count, output, 14: texels written in the current or last transaction, saturating at 16383.

Function
REQ-013 SHALL pass tex_csb, tex_sclk and tex_mosi each through a 2-flop synchroniser before use.
REQ-014 SHALL sample mosi on each detected rising edge of synchronised sclk; the requirement is f_clk >= 4*f_sclk.
REQ-015 SHALL shift 8 bits MSB-first per byte and raise an internal byte_valid for exactly one clk on the 8th sampled edge.
REQ-016 SHALL run FSM states IDLE, ADDR_HI, ADDR_LO, DATA.
REQ-017 SHALL go IDLE->ADDR_HI on synchronised CSB falling, clearing the bit counter and load_count.
REQ-018 SHALL, in ADDR_HI on byte_valid, latch byte[ADDR_BITS-9:0] as wr_addr[ADDR_BITS-1:8] and go to ADDR_LO; the upper 3 bits are ignored.
REQ-019 SHALL, in ADDR_LO on byte_valid, latch the byte as wr_addr[7:0] and go to DATA.
REQ-020 SHALL, in DATA on byte_valid, drive wr_en=1 for one clk in the following cycle, with wr_data=byte[CHANNEL_BITS*3-1:0] at the current wr_addr.
REQ-021 SHALL increment wr_addr by one in the cycle after each wr_en, wrapping 8191->0.
REQ-022 SHALL hold wr_addr and wr_data stable whenever wr_en=0.
REQ-023 SHALL return any state to IDLE on synchronised CSB rising and discard any partial byte.
REQ-024 SHALL give CSB rising priority when it coincides with byte_valid: no write occurs.
REQ-025 SHALL ignore sclk edges while CSB is high.
REQ-026 SHALL increment load_count on each wr_en and hold it at 16383 once reached.
REQ-027 SHALL leave load_count unchanged on return to IDLE.

Reset
REQ-028 SHALL, on reset_n low, immediately set state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, load_count=0, the shift register and bit counter to 0, and all synchroniser flops to idle (csb=1, sclk=0, mosi=0).
REQ-029 SHALL abandon a transaction when reset occurs mid-transaction; after release, the block waits for a fresh CSB falling edge (CSB already low is not a start).

Structure
REQ-030 SHALL put TEX_ADDR_BITS=13, the texel address field offsets (col 0..5, side 6, row 7..12) and the FSM state encoding in a shared package, also used by the texture memory.
REQ-031 SHALL place the synchronisers, sclk edge detect and byte shifter in sub-module spi_byte_rx (outputs byte[7:0] and byte_valid).

Verification
REQ-032 SHALL cover: CSB low, bytes 0x00 0x00 0x2A 0x15, CSB high -> writes (addr 0, data 0x2A) then (1, 0x15); load_count=2.
REQ-033 SHALL cover: address bytes 0x1F 0xFF then data 0x01 0x02 -> writes at 8191 then 0 (wrap).
REQ-034 SHALL cover: address 0x00 0x40 then 4 data bits only, CSB high -> no wr_en, state IDLE, load_count=0.
REQ-035 SHALL cover: reset_n low in the middle of a data byte -> all outputs 0 at once; after release with CSB still low, further sclk edges produce no writes.
REQ-036 SHALL cover: 16390 data bytes in one transaction -> load_count saturates at 16383 while writes continue.
REQ-037 SHALL cover: f_sclk = f_clk/4 with random data over 8192 texels -> memory image matches the sent bytes masked to 6 bits.
